// File: rtl/gol_host_sequencer_if.sv
// Bus bundle between the host sequencer and its environment: load stream, memory
// port s2, Game of Life engine control and result stream.
interface gol_host_sequencer_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              cmd_run;
  logic [7:0]        load_data;
  logic              load_valid;
  logic              load_ready;
  logic              mem_owner;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [7:0]        mem_writedata;
  logic [7:0]        mem_readdata;
  logic [ADDR_W-1:0] gol_start_address;
  logic              gol_initialize;
  logic              gol_start;
  logic              gol_completed;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  cmd_run, load_data, load_valid, mem_readdata, gol_completed, out_ready,
    output load_ready, mem_owner, mem_address, mem_write, mem_writedata, gol_start_address,
           gol_initialize, gol_start, out_data, out_valid, out_last, busy, done, error
  );

  modport slave (
    output cmd_run, load_data, load_valid, mem_readdata, gol_completed, out_ready,
    input  load_ready, mem_owner, mem_address, mem_write, mem_writedata, gol_start_address,
           gol_initialize, gol_start, out_data, out_valid, out_last, busy, done, error
  );
endinterface

// File: rtl/gol_host_sequencer.sv
// FPGA-side initiator for the Game of Life engine: loads a board into memory, runs the
// initialize/start/completed handshake, then streams the result board back out.
module gol_host_sequencer #(
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       BOARD_BYTES = 256,
  parameter logic [ADDR_W-1:0] START_ADDR  = 12'h000,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 12'h100,
  parameter int unsigned       TIMEOUT_CYC = 50_000_000
) (
  input  logic                 fpga_clk_50,
  input  logic                 hps_fpga_reset_n,
  gol_host_sequencer_if.master bus
);

  localparam int unsigned CntW = $clog2(BOARD_BYTES + 1);
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BOARD_BYTES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLoad    = 4'd1;
  localparam logic [3:0] StInit    = 4'd2;
  localparam logic [3:0] StStart   = 4'd3;
  localparam logic [3:0] StWaitHi  = 4'd4;
  localparam logic [3:0] StRelease = 4'd5;
  localparam logic [3:0] StRdAddr  = 4'd6;
  localparam logic [3:0] StRdData  = 4'd7;
  localparam logic [3:0] StOut     = 4'd8;
  localparam logic [3:0] StFinish  = 4'd9;
  localparam logic [3:0] StError   = 4'd10;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            error_q, error_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            engine_owns;

  // Next-state and counter update logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    error_d     = error_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_run) begin
          state_d = StLoad;
          cnt_d   = '0;
          error_d = 1'b0;
        end
      end
      StLoad: begin
        if (bus.load_valid) begin
          if (cnt_q == LastCnt) begin
            state_d = StInit;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StInit: state_d = StStart;
      StStart: begin
        tmo_d   = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (bus.gol_completed) begin
          state_d = StRelease;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StError;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRelease: begin
        // Second half of the 4-phase handshake: engine must drop completed.
        if (!bus.gol_completed) begin
          state_d = StRdAddr;
          cnt_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StError;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRdAddr: state_d = StRdData;
      StRdData: begin
        // Address was presented last cycle, so read data is valid now.
        out_data_d  = bus.mem_readdata;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == LastCnt);
        state_d     = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = StFinish;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      StFinish: state_d = StIdle;
      StError:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      error_q     <= error_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Memory port drive; address is forced to zero whenever the engine owns the port.
  always_comb begin
    engine_owns       = 1'b0;
    bus.mem_address   = '0;
    case (state_q)
      StInit, StStart, StWaitHi, StRelease: engine_owns = 1'b1;
      StLoad:                     bus.mem_address = START_ADDR + ADDR_W'(cnt_q);
      StRdAddr, StRdData, StOut:  bus.mem_address = RESULT_ADDR + ADDR_W'(cnt_q);
      default: ;
    endcase
  end

  assign bus.mem_owner         = !engine_owns;
  assign bus.load_ready        = (state_q == StLoad);
  assign bus.mem_write         = (state_q == StLoad) && bus.load_valid;
  assign bus.mem_writedata     = (state_q == StLoad) ? bus.load_data : 8'h00;
  assign bus.gol_start_address = START_ADDR;
  assign bus.gol_initialize    = (state_q == StInit);
  assign bus.gol_start         = (state_q == StStart) || (state_q == StWaitHi);
  assign bus.out_data          = out_data_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_last          = out_last_q;
  assign bus.busy              = (state_q != StIdle);
  assign bus.done              = (state_q == StFinish);
  assign bus.error             = error_q;

endmodule

// File: tb/tb_gol_host_sequencer.sv
// Scoreboard bench for gol_host_sequencer: memory and engine models, write and result
// scoreboards, a second instance with a short timeout.
`timescale 1ns/1ps
module tb_gol_host_sequencer;
  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned BOARD_BYTES = 256;
  localparam logic [11:0] START_ADDR  = 12'h000;
  localparam logic [11:0] RESULT_ADDR = 12'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gol_host_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  gol_host_sequencer_if #(.ADDR_W(ADDR_W)) tbus ();

  gol_host_sequencer #(
    .ADDR_W(ADDR_W), .BOARD_BYTES(BOARD_BYTES), .START_ADDR(START_ADDR),
    .RESULT_ADDR(RESULT_ADDR), .TIMEOUT_CYC(1000)
  ) u_dut (
    .fpga_clk_50(clk), .hps_fpga_reset_n(rst_n), .bus(bus)
  );

  gol_host_sequencer #(
    .ADDR_W(ADDR_W), .BOARD_BYTES(BOARD_BYTES), .START_ADDR(START_ADDR),
    .RESULT_ADDR(RESULT_ADDR), .TIMEOUT_CYC(50)
  ) u_dut_tmo (
    .fpga_clk_50(clk), .hps_fpga_reset_n(rst_n), .bus(tbus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Result region holds A5 ^ low address byte; anything else reads 3C.
  always @(posedge clk) begin
    if (bus.mem_address[11:8] == 4'h1) bus.mem_readdata <= 8'hA5 ^ bus.mem_address[7:0];
    else bus.mem_readdata <= 8'h3C;
  end

  // Engine: completed 100 cycles after start, drops 5 cycles after start falls.
  logic eng_en;
  int   eng_up, eng_dn;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gol_completed <= 1'b0;
      eng_up <= 0;
      eng_dn <= 0;
    end else if (eng_en) begin
      if (bus.gol_start && !bus.gol_completed) begin
        eng_up <= eng_up + 1;
        if (eng_up == 99) bus.gol_completed <= 1'b1;
      end
      if (!bus.gol_start && bus.gol_completed) begin
        eng_dn <= eng_dn + 1;
        if (eng_dn == 4) begin
          bus.gol_completed <= 1'b0;
          eng_up <= 0;
          eng_dn <= 0;
        end
      end
    end
  end

  logic [19:0] exp_wr[$];
  logic [8:0]  exp_out[$];
  logic [19:0] wr_e;
  logic [8:0]  out_e;
  int done_cnt = 0, init_cnt = 0, out_seen = 0, t_done_cnt = 0;
  logic prev_init = 1'b0, prev_cmp = 1'b0, cmp_rise = 1'b0;
  logic stall_v = 1'b0;
  logic [7:0] stall_d = 8'h00;

  // Negedge monitor: ownership rules, write and result scoreboards, pulse counts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.mem_owner) begin
        check("own_write", 32'(bus.mem_write), 32'd0);
        check("own_addr", 32'(bus.mem_address), 32'd0);
      end
      if (bus.mem_write) begin
        check("wr_queue", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          wr_e = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_address), 32'(wr_e[19:8]));
          check("wr_data", 32'(bus.mem_writedata), 32'(wr_e[7:0]));
        end
      end
      if (prev_init) check("start_after_init", 32'(bus.gol_start), 32'd1);
      if (bus.gol_initialize) init_cnt++;
      prev_init = bus.gol_initialize;
      if (cmp_rise) check("start_fall", 32'(bus.gol_start), 32'd0);
      cmp_rise = bus.gol_completed && !prev_cmp;
      if (cmp_rise) check("start_hold", 32'(bus.gol_start), 32'd1);
      prev_cmp = bus.gol_completed;
      if (bus.out_valid) begin
        if (stall_v) check("out_stable", 32'(bus.out_data), 32'(stall_d));
        if (bus.out_ready) begin
          check("out_queue", 32'(exp_out.size() != 0), 32'd1);
          if (exp_out.size() != 0) begin
            out_e = exp_out.pop_front();
            check("out_data", 32'(bus.out_data), 32'(out_e[7:0]));
            check("out_last", 32'(bus.out_last), 32'(out_e[8]));
          end
          out_seen++;
          stall_v = 1'b0;
        end else begin
          stall_v = 1'b1;
          stall_d = bus.out_data;
        end
      end
      if (bus.done) done_cnt++;
      if (tbus.done) t_done_cnt++;
    end
  end

  task automatic check_rst();
    check("rst_owner", 32'(bus.mem_owner), 32'd1);
    check("rst_start", 32'(bus.gol_start), 32'd0);
    check("rst_init", 32'(bus.gol_initialize), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_lready", 32'(bus.load_ready), 32'd0);
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("rst_olast", 32'(bus.out_last), 32'd0);
    check("rst_odata", 32'(bus.out_data), 32'd0);
    check("rst_saddr", 32'(bus.gol_start_address), 32'(START_ADDR));
  endtask

  task automatic pulse_run();
    @(posedge clk); #1 bus.cmd_run = 1'b1;
    @(posedge clk); #1 bus.cmd_run = 1'b0;
  endtask

  task automatic load_byte(input int unsigned idx, input logic [7:0] d, input int unsigned gap);
    int b;
    repeat (gap) begin @(posedge clk); #1 bus.load_valid = 1'b0; end
    @(posedge clk); #1 bus.load_valid = 1'b1;
    bus.load_data = d;
    exp_wr.push_back({START_ADDR + 12'(idx), d});
    b = 0;
    do begin @(negedge clk); b++; end while (!bus.load_ready && b < 100);
    check("load_accept", 32'(bus.load_ready), 32'd1);
  endtask

  task automatic load_board(input bit rnd);
    for (int i = 0; i < BOARD_BYTES; i++)
      load_byte(i, rnd ? 8'($urandom) : 8'(i), rnd ? $urandom_range(0, 3) : 0);
    @(posedge clk); #1 bus.load_valid = 1'b0;
  endtask

  task automatic run(input bit rnd, input bit inject);
    int b;
    done_cnt = 0;
    init_cnt = 0;
    out_seen = 0;
    for (int i = 0; i < BOARD_BYTES; i++)
      exp_out.push_back({(i == BOARD_BYTES - 1), 8'hA5 ^ 8'(i)});
    pulse_run();
    check("busy_run", 32'(bus.busy), 32'd1);
    fork
      load_board(rnd);
      begin
        int cb, stall;
        cb = 0;
        stall = 0;
        while (out_seen < BOARD_BYTES && cb < 20000) begin
          @(posedge clk); #1;
          cb++;
          if (bus.out_valid) begin
            if (stall > 0) begin bus.out_ready = 1'b0; stall--; end
            else bus.out_ready = 1'b1;
          end else begin
            bus.out_ready = 1'b0;
            stall = rnd ? $urandom_range(0, 7) : 0;
          end
        end
      end
      if (inject) begin
        int ib;
        repeat (40) @(posedge clk);
        #1 bus.cmd_run = 1'b1;
        @(posedge clk); #1 bus.cmd_run = 1'b0;
        ib = 0;
        while (!bus.out_valid && ib < 5000) begin @(posedge clk); #1; ib++; end
        bus.cmd_run = 1'b1;
        @(posedge clk); #1 bus.cmd_run = 1'b0;
      end
    join
    check("out_count", 32'(out_seen), 32'(BOARD_BYTES));
    b = 0;
    while (done_cnt == 0 && b < 100) begin @(negedge clk); b++; end
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("init_cnt", 32'(init_cnt), 32'd1);
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("out_left", 32'(exp_out.size()), 32'd0);
    check("busy_end", 32'(bus.busy), 32'd0);
    check("error_end", 32'(bus.error), 32'd0);
  endtask

  task automatic timeout_test();
    int b, hi;
    t_done_cnt = 0;
    @(posedge clk); #1 tbus.cmd_run = 1'b1;
    @(posedge clk); #1 tbus.cmd_run = 1'b0;
    b = 0;
    while (!tbus.gol_start && b < 1000) begin @(negedge clk); b++; end
    check("t_start", 32'(tbus.gol_start), 32'd1);
    hi = 0;
    b = 0;
    while (!tbus.error && b < 200) begin
      if (tbus.gol_start) hi++;
      @(negedge clk);
      b++;
    end
    // One START cycle plus 50 WAIT_HI cycles before the error shows.
    check("t_start_cycles", 32'(hi), 32'd51);
    check("t_error", 32'(tbus.error), 32'd1);
    check("t_start_low", 32'(tbus.gol_start), 32'd0);
    check("t_owner", 32'(tbus.mem_owner), 32'd1);
    @(negedge clk);
    check("t_idle", 32'(tbus.busy), 32'd0);
    check("t_sticky", 32'(tbus.error), 32'd1);
    check("t_no_done", 32'(t_done_cnt), 32'd0);
    @(posedge clk); #1 tbus.cmd_run = 1'b1;
    @(posedge clk); #1 tbus.cmd_run = 1'b0;
    check("t_err_clr", 32'(tbus.error), 32'd0);
    check("t_busy_again", 32'(tbus.busy), 32'd1);
  endtask

  task automatic reset_test();
    int b;
    eng_en = 1'b0;
    done_cnt = 0;
    pulse_run();
    load_board(1'b0);
    b = 0;
    while (!bus.gol_start && b < 100) begin @(negedge clk); b++; end
    check("r_start", 32'(bus.gol_start), 32'd1);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_rst();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("r_no_done", 32'(done_cnt), 32'd0);
    check("r_no_error", 32'(bus.error), 32'd0);
    check("r_idle", 32'(bus.busy), 32'd0);
    check("r_wr_left", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    bus.cmd_run = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = 8'h00;
    bus.out_ready = 1'b0;
    tbus.cmd_run = 1'b0;
    tbus.load_valid = 1'b1;
    tbus.load_data = 8'h00;
    tbus.out_ready = 1'b1;
    tbus.gol_completed = 1'b0;
    tbus.mem_readdata = 8'h00;
    eng_en = 1'b1;
    #23 check_rst();
    @(posedge clk); #1 rst_n = 1'b1;
    run(1'b0, 1'b0);
    run(1'b1, 1'b1);
    timeout_test();
    reset_test();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end
endmodule
